// File: rtl/ram_pattern_tester.sv
// RAM self-test engine: writes a pattern to BlockCount consecutive blocks through the
// RAMController command/write/read handshake, reads it back and reports mismatches.
module ram_pattern_tester #(
    parameter int unsigned BlockSize     = 16,
    parameter int unsigned BlockWidth    = 21,
    parameter int unsigned WordWidth     = 16,
    parameter int unsigned BlockCount    = 4,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned StopOnError   = 1
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [BlockWidth-1:0]        start_block,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [15:0]                  err_count,
    output logic [BlockWidth-1:0]        err_block,
    output logic [$clog2(BlockSize)-1:0] err_word,
    output logic [WordWidth-1:0]         err_data,
    output logic [1:0]                   cmd,
    output logic [BlockWidth-1:0]        cmd_block,
    input  logic                         write_ready,
    output logic                         write_trigger,
    output logic [WordWidth-1:0]         write_data,
    input  logic                         read_ready,
    output logic                         read_trigger,
    input  logic [WordWidth-1:0]         read_data
);

    localparam int unsigned WordIdxW = $clog2(BlockSize);
    localparam int unsigned BlkCntW  = $clog2(BlockCount + 1);
    localparam int unsigned TmoW     = $clog2(TimeoutCycles + 1);

    // RAMController command encoding
    localparam logic [1:0] CmdNone  = 2'd0;
    localparam logic [1:0] CmdWrite = 2'd1;
    localparam logic [1:0] CmdRead  = 2'd2;

    typedef enum logic [3:0] {
        StIdle, StWrCmd, StWrWait, StWrData, StRdCmd, StRdWait, StRdData, StNext, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [WordIdxW-1:0]   word_q, word_d;
    logic [BlkCntW-1:0]    blk_cnt_q, blk_cnt_d;
    logic [BlockWidth-1:0] block_q, block_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic [1:0]            mode_q, mode_d;
    logic [15:0]           err_count_q, err_count_d;
    logic [BlockWidth-1:0] err_block_q, err_block_d;
    logic [WordIdxW-1:0]   err_word_q, err_word_d;
    logic [WordWidth-1:0]  err_data_q, err_data_d;
    logic                  timeout_q, timeout_d;

    logic [WordWidth-1:0]  pat;
    logic                  last_word, tmo_expired, wr_xfer, rd_xfer, mismatch;

    function automatic logic [WordWidth-1:0] pattern(input logic [1:0]            m,
                                                     input logic [BlockWidth-1:0] b,
                                                     input logic [WordIdxW-1:0]   w);
        logic [BlockWidth-1:0] x;
        logic [WordWidth-1:0]  p;
        x = b ^ BlockWidth'(w);
        p = '0;
        unique case (m)
            2'd0: p = WordWidth'(x);
            2'd1: p = WordWidth'(~x);
            2'd2: p = WordWidth'(1) << (32'(w) % WordWidth);
            default: begin
                // Odd words get 'h5555.., even words 'hAAAA..
                for (int i = 0; i < int'(WordWidth); i++) begin
                    p[i] = w[0] ? ~i[0] : i[0];
                end
            end
        endcase
        return p;
    endfunction

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        blk_cnt_d   = blk_cnt_q;
        block_d     = block_q;
        mode_d      = mode_q;
        err_count_d = err_count_q;
        err_block_d = err_block_q;
        err_word_d  = err_word_q;
        err_data_d  = err_data_q;
        timeout_d   = timeout_q;

        pat         = pattern(mode_q, block_q, word_q);
        last_word   = (word_q == WordIdxW'(BlockSize - 1));
        tmo_expired = (tmo_q == TmoW'(TimeoutCycles - 1));
        wr_xfer     = (state_q == StWrData) && write_ready;
        rd_xfer     = (state_q == StRdData) && read_ready;
        mismatch    = rd_xfer && (read_data != pat);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StWrCmd;
                    mode_d      = mode;
                    block_d     = start_block;
                    blk_cnt_d   = '0;
                    err_count_d = '0;
                    err_block_d = '0;
                    err_word_d  = '0;
                    err_data_d  = '0;
                    timeout_d   = 1'b0;
                end
            end
            StWrCmd: begin
                word_d  = '0;
                state_d = StWrWait;
            end
            StWrWait: state_d = StWrData;
            StWrData: begin
                if (wr_xfer) begin
                    word_d = word_q + WordIdxW'(1);
                    if (last_word) state_d = StRdCmd;
                end else if (tmo_expired) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StRdCmd: begin
                word_d  = '0;
                state_d = StRdWait;
            end
            StRdWait: state_d = StRdData;
            StRdData: begin
                if (rd_xfer) begin
                    word_d = word_q + WordIdxW'(1);
                    if (mismatch) begin
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                        if (err_count_q == '0) begin
                            err_block_d = block_q;
                            err_word_d  = word_q;
                            err_data_d  = read_data;
                        end
                    end
                    if (mismatch && (StopOnError != 0)) begin
                        state_d = StDone;
                    end else if (last_word) begin
                        state_d = StNext;
                    end
                end else if (tmo_expired) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StNext: begin
                if (blk_cnt_q == BlkCntW'(BlockCount - 1)) begin
                    state_d = StDone;
                end else begin
                    blk_cnt_d = blk_cnt_q + BlkCntW'(1);
                    block_d   = block_q + BlockWidth'(1);
                    state_d   = StWrCmd;
                end
            end
            default: state_d = StIdle;
        endcase

        // Stall counter only runs while waiting on the controller in a data phase
        if ((state_d != state_q) || wr_xfer || rd_xfer) begin
            tmo_d = '0;
        end else if ((state_q == StWrData) || (state_q == StRdData)) begin
            tmo_d = tmo_q + TmoW'(1);
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= StIdle;
            word_q      <= '0;
            blk_cnt_q   <= '0;
            block_q     <= '0;
            tmo_q       <= '0;
            mode_q      <= '0;
            err_count_q <= '0;
            err_block_q <= '0;
            err_word_q  <= '0;
            err_data_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            blk_cnt_q   <= blk_cnt_d;
            block_q     <= block_d;
            tmo_q       <= tmo_d;
            mode_q      <= mode_d;
            err_count_q <= err_count_d;
            err_block_q <= err_block_d;
            err_word_q  <= err_word_d;
            err_data_q  <= err_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy          = (state_q != StIdle) && (state_q != StDone);
    assign done          = (state_q == StDone);
    assign pass          = done && (err_count_q == '0) && !timeout_q;
    assign timeout       = timeout_q;
    assign err_count     = err_count_q;
    assign err_block     = err_block_q;
    assign err_word      = err_word_q;
    assign err_data      = err_data_q;
    assign cmd           = (state_q == StWrCmd) ? CmdWrite :
                           (state_q == StRdCmd) ? CmdRead  : CmdNone;
    assign cmd_block     = block_q;
    assign write_trigger = (state_q == StWrData);
    assign read_trigger  = (state_q == StRdData);
    assign write_data    = pat;

endmodule
